fetch_prefetch_unit: RTL and testbench



---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_queue.sv | 71 +++++++
 rtl/fetch_prefetch_unit.sv | 176 +++++++++++++++++
 tb/tb_fetch_prefetch_unit.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch/prefetch unit.
package fetch_pkg;

    localparam int unsigned ILEN    = 32;
    localparam int unsigned PC_STEP = 4;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        DRAIN
    } fetch_state_e;

    // Queue entry for the default 32-bit PC build; the queue itself stores a flat word.
    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [31:0]     pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO: power-of-two depth, wrapping pointers, synchronous flush, occupancy count.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned WIDTH = ILEN + 32,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             PCrst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_en, pop_en;

    // Flush wins over a same-cycle push or pop; both are dropped.
    assign push_en = push_i && !flush_i && (count_q != CW'(DEPTH));
    assign pop_en  = pop_i  && !flush_i && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_en) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_en)  rd_ptr_d = rd_ptr_q + PW'(1);
            unique case ({push_en, pop_en})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge PCrst_i) begin
        if (!PCrst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the count qualifies every read.
    always_ff @(posedge clk_i) begin
        if (push_en) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Fetch stage: PC generator, credit-limited pipelined imem requests, prefetch queue, redirects.
// Optional redirect-target misalignment trap: define FETCH_MISALIGN_CHECK_EN.
module fetch_prefetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned      XLEN            = 32,
    parameter int unsigned      DEPTH           = 4,
    parameter int unsigned      MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0]  RESET_PC        = '0
) (
    input  logic            clk_i,
    input  logic            PCrst_i,
    output logic            imem_req_valid_o,
    input  logic            imem_req_ready_i,
    output logic [XLEN-1:0] imem_req_addr_o,
    input  logic            imem_rsp_valid_i,
    input  logic [31:0]     imem_rsp_data_i,
    output logic            dec_valid_o,
    input  logic            dec_ready_i,
    output logic [31:0]     dec_instr_o,
    output logic [XLEN-1:0] dec_pc_o,
    input  logic            br_i,
    input  logic            jal_i,
    input  logic            jalr_i,
    input  logic [XLEN-1:0] ex_pc_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] imm_i,
    output logic [XLEN-1:0] link_o,
    output logic            misalign_o
);

    localparam int unsigned EW = ILEN + XLEN;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = CW + 1;

    fetch_state_e     state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]    outstanding_q, outstanding_d;
    logic [CW-1:0]    drop_q, drop_d;

    logic             redirect;
    logic [XLEN-1:0]  target_raw, target;
    logic             tgt_misaligned;
    logic             halt;
    logic             credit_ok;
    logic [SW-1:0]    in_flight;
    logic             req_fire;
    logic             rsp_accept;
    logic [CW-1:0]    q_count;
    logic             q_empty;
    logic [EW-1:0]    q_head;

    assign redirect   = br_i | jal_i | jalr_i;
    assign target_raw = jalr_i ? ((rs1_i + imm_i) & ~XLEN'(1)) : (ex_pc_i + imm_i);
    assign link_o     = ex_pc_i + XLEN'(PC_STEP);

`ifdef FETCH_MISALIGN_CHECK_EN
    logic halt_q, halt_d;
    logic misalign_q, misalign_d;

    assign target         = target_raw;
    assign tgt_misaligned = target_raw[1];

    // A misaligned redirect parks the fetcher until a later redirect supplies a good target.
    always_comb begin
        halt_d     = halt_q;
        misalign_d = 1'b0;
        if (redirect) begin
            halt_d     = tgt_misaligned;
            misalign_d = tgt_misaligned;
        end
    end

    always_ff @(posedge clk_i or negedge PCrst_i) begin
        if (!PCrst_i) begin
            halt_q     <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            halt_q     <= halt_d;
            misalign_q <= misalign_d;
        end
    end

    assign halt       = halt_q;
    assign misalign_o = misalign_q;
`else
    assign target         = target_raw & ~XLEN'(3);
    assign tgt_misaligned = 1'b0;
    assign halt           = 1'b0;
    assign misalign_o     = 1'b0;
`endif

    // Credits cover both queued entries and responses still in flight, so a push never overflows.
    assign in_flight = SW'(outstanding_q) + SW'(q_count);
    assign credit_ok = (in_flight < SW'(DEPTH)) && (outstanding_q < CW'(MAX_OUTSTANDING));

    assign imem_req_valid_o = (state_q == RUN) && !redirect && !halt && credit_ok;
    assign imem_req_addr_o  = pc_q;
    assign req_fire         = imem_req_valid_o && imem_req_ready_i;
    assign rsp_accept       = imem_rsp_valid_i && (drop_q == '0);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        rsp_pc_d      = rsp_pc_q;
        drop_d        = drop_q;
        outstanding_d = outstanding_q;

        unique case ({req_fire, imem_rsp_valid_i})
            2'b10:   outstanding_d = outstanding_q + CW'(1);
            2'b01:   outstanding_d = outstanding_q - CW'(1);
            default: outstanding_d = outstanding_q;
        endcase

        if (req_fire)                      pc_d     = pc_q + XLEN'(PC_STEP);
        if (rsp_accept)                    rsp_pc_d = rsp_pc_q + XLEN'(PC_STEP);
        if (imem_rsp_valid_i && !rsp_accept) drop_d = drop_q - CW'(1);

        if (redirect) begin
            // Everything still owed by memory is stale, including a response landing now.
            drop_d = outstanding_d;
            if (!tgt_misaligned) begin
                pc_d     = target;
                rsp_pc_d = target;
            end
        end

        unique case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (redirect && (outstanding_d != '0)) state_d = DRAIN;
            end
            DRAIN: begin
                if (!redirect && (drop_d == '0)) state_d = RUN;
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk_i or negedge PCrst_i) begin
        if (!PCrst_i) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    fetch_queue #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk_i       (clk_i),
        .PCrst_i     (PCrst_i),
        .flush_i     (redirect),
        .push_i      (rsp_accept),
        .push_data_i ({imem_rsp_data_i, rsp_pc_q}),
        .pop_i       (dec_valid_o && dec_ready_i),
        .head_o      (q_head),
        .empty_o     (q_empty),
        .count_o     (q_count)
    );

    assign dec_valid_o = !q_empty;
    assign dec_instr_o = q_head[EW-1 -: ILEN];
    assign dec_pc_o    = q_head[XLEN-1:0];

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Scoreboard bench for fetch_prefetch_unit with a 1-cycle-latency memory model.
module tb_fetch_prefetch_unit;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned MAXO  = 2;
`ifdef FETCH_MISALIGN_CHECK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic            clk, rst_n;
    logic            req_valid, req_ready;
    logic [31:0]     req_addr;
    logic            rsp_valid;
    logic [31:0]     rsp_data;
    logic            dec_valid, dec_ready;
    logic [31:0]     dec_instr, dec_pc;
    logic            br, jal, jalr;
    logic [31:0]     ex_pc, rs1, imm, link;
    logic            misalign;

    int              n_tests, n_fail;
    int              pop_cnt, fire_cnt;
    bit              mon_en, rsp_en;
    logic [31:0]     exp_next_addr, exp_target;
    logic            exp_misalign;
    logic [31:0]     mem_q[$];
    logic [63:0]     sb[$];

    fetch_prefetch_unit #(
        .XLEN            (XLEN),
        .DEPTH           (DEPTH),
        .MAX_OUTSTANDING (MAXO),
        .RESET_PC        (32'h100)
    ) dut (
        .clk_i            (clk),
        .PCrst_i          (rst_n),
        .imem_req_valid_o (req_valid),
        .imem_req_ready_i (req_ready),
        .imem_req_addr_o  (req_addr),
        .imem_rsp_valid_i (rsp_valid),
        .imem_rsp_data_i  (rsp_data),
        .dec_valid_o      (dec_valid),
        .dec_ready_i      (dec_ready),
        .dec_instr_o      (dec_instr),
        .dec_pc_o         (dec_pc),
        .br_i             (br),
        .jal_i            (jal),
        .jalr_i           (jalr),
        .ex_pc_i          (ex_pc),
        .rs1_i            (rs1),
        .imm_i            (imm),
        .link_o           (link),
        .misalign_o       (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC0DE, a[15:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: decides what happens at the coming edge and scores it.
    initial begin
        logic [63:0] e;
        int          occ;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (br || jal || jalr) begin
                    sb.delete();
                    if (!exp_misalign) exp_next_addr = exp_target;
                end else begin
                    occ = sb.size();
                    if (dec_valid && dec_ready) begin
                        pop_cnt++;
                        if (sb.size() == 0) begin
                            n_tests++;
                            n_fail++;
                            $display("FAIL dec_pop: unexpected entry pc %0h", dec_pc);
                        end else begin
                            e = sb.pop_front();
                            check("dec_pc", 64'(dec_pc), 64'(e[31:0]));
                            check("dec_instr", 64'(dec_instr), 64'(e[63:32]));
                        end
                    end
                    if (req_valid && req_ready) begin
                        fire_cnt++;
                        check("req_addr", 64'(req_addr), 64'(exp_next_addr));
                        check("credit", 64'(occ < int'(DEPTH)), 64'd1);
                        sb.push_back({mem_word(exp_next_addr), exp_next_addr});
                        mem_q.push_back(req_addr);
                        exp_next_addr = exp_next_addr + 32'd4;
                    end
                end
            end
        end
    end

    // Memory: answers in order, one cycle after acceptance, when enabled.
    initial begin
        rsp_valid = 1'b0;
        rsp_data  = '0;
        forever begin
            @(posedge clk);
            #2;
            if (rsp_en && mem_q.size() > 0) begin
                rsp_valid = 1'b1;
                rsp_data  = mem_word(mem_q.pop_front());
            end else begin
                rsp_valid = 1'b0;
                rsp_data  = '0;
            end
        end
    end

    task automatic redirect(input logic b, input logic j, input logic jr, input logic [31:0] epc,
                            input logic [31:0] r1, input logic [31:0] im,
                            input logic [31:0] tgt, input logic mis);
        @(posedge clk);
        #1;
        exp_target   = tgt;
        exp_misalign = mis;
        br = b; jal = j; jalr = jr; ex_pc = epc; rs1 = r1; imm = im;
        @(negedge clk);
        check("link", 64'(link), 64'(epc + 32'd4));
        @(posedge clk);
        #1;
        br = 1'b0; jal = 1'b0; jalr = 1'b0;
        @(negedge clk);
        check("flush_dec_valid", 64'(dec_valid), 64'd0);
        check("misalign_pulse", 64'(misalign), 64'(mis));
        @(negedge clk);
        check("misalign_clear", 64'(misalign), 64'd0);
    endtask

    task automatic first_pc(input string name, input logic [31:0] exp);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (dec_valid) begin
                check(name, 64'(dec_pc), 64'(exp));
                return;
            end
        end
        n_tests++;
        n_fail++;
        $display("FAIL %s: timeout, no entry, expected pc %0h", name, exp);
    endtask

    initial begin
        int p, f;
        n_tests = 0; n_fail = 0; pop_cnt = 0; fire_cnt = 0;
        mon_en = 1'b0; rsp_en = 1'b1;
        rst_n = 1'b0; req_ready = 1'b1; dec_ready = 1'b1;
        br = 1'b0; jal = 1'b0; jalr = 1'b0; ex_pc = '0; rs1 = '0; imm = '0;
        exp_next_addr = 32'h100; exp_target = '0; exp_misalign = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_req_valid", 64'(req_valid), 64'd0);
        check("rst_dec_valid", 64'(dec_valid), 64'd0);
        check("rst_misalign", 64'(misalign), 64'd0);

        // Reset release; BOOT holds requests for exactly one cycle.
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        check("boot_idle", 64'(req_valid), 64'd0);
        @(negedge clk);
        check("run_req_valid", 64'(req_valid), 64'd1);
        check("run_first_addr", 64'(req_addr), 64'h100);
        repeat (12) @(negedge clk);
        check("stream_rate", 64'(pop_cnt >= 8), 64'd1);

        // Decode stall: credits cap queue + in-flight at DEPTH.
        @(posedge clk);
        #1;
        dec_ready = 1'b0;
        repeat (10) @(negedge clk);
        check("stall_req_stop", 64'(req_valid), 64'd0);
        check("stall_fill", 64'(sb.size()), 64'(DEPTH));
        check("stall_dec_valid", 64'(dec_valid), 64'd1);
        p = pop_cnt;
        @(posedge clk);
        #1;
        dec_ready = 1'b1;
        repeat (6) @(negedge clk);
        check("stall_drain", 64'(pop_cnt - p >= 4), 64'd1);

        // Branch with two responses owed: both must be discarded.
        @(posedge clk);
        #1;
        rsp_en = 1'b0;
        repeat (4) @(negedge clk);
        check("owed_two", 64'(mem_q.size()), 64'(MAXO));
        check("owed_req_stop", 64'(req_valid), 64'd0);
        redirect(1'b1, 1'b0, 1'b0, 32'h200, 32'h0, 32'hFFFF_FFF8, 32'h1F8, 1'b0);
        rsp_en = 1'b1;
        first_pc("br_first_pc", 32'h1F8);
        repeat (4) @(negedge clk);

        // JALR beats JAL in the same cycle.
        redirect(1'b0, 1'b1, 1'b1, 32'h300, 32'h1001, 32'h4, 32'h1004, 1'b0);
        first_pc("jalr_first_pc", 32'h1004);
        repeat (4) @(negedge clk);

        // Memory back-pressure: address holds, PC advances only on handshake.
        @(posedge clk);
        #1;
        req_ready = 1'b0;
        f = fire_cnt;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_valid", 64'(req_valid), 64'd1);
            check("bp_addr_stable", 64'(req_addr), 64'(exp_next_addr));
        end
        check("bp_no_fire", 64'(fire_cnt), 64'(f));
        @(posedge clk);
        #1;
        req_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("bp_resume", 64'(fire_cnt > f), 64'd1);

        // Branch to 0x102: trapped with the check, word-aligned to 0x100 without it.
        if (MIS_EN) begin
            redirect(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 32'h2, 32'h0, 1'b1);
            f = fire_cnt;
            repeat (10) @(negedge clk);
            check("mis_no_fire", 64'(fire_cnt), 64'(f));
            check("mis_req_valid", 64'(req_valid), 64'd0);
        end else begin
            redirect(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 32'h2, 32'h100, 1'b0);
            first_pc("align_first_pc", 32'h100);
        end
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
